// File: rtl/md_unit.sv
// Multicycle multiply/divide unit: MULT/MULTU/DIV/DIVU producing {HI,LO} plus a done strobe.
`timescale 1ns/1ps
module md_unit #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        md_cancel,
    output logic        md_busy,
    output logic        md_done,
    output logic [63:0] md_result
);

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned DIV_LAST = 31;
    localparam int unsigned MUL_LAST = MUL_LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               uns_q, uns_d;
    logic [31:0]        src1_q, src1_d;
    logic [31:0]        src2_q, src2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        rq_q, rq_d;
    logic [63:0]        result_q, result_d;

    logic               accept;
    logic               mul_last;
    logic               div_last;
    logic [31:0]        dvd_in_abs;
    logic [31:0]        dvs_abs;
    logic [32:0]        rem_sh;
    logic [32:0]        diff;
    logic [63:0]        rq_iter;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic               q_neg;
    logic               r_neg;
    logic [63:0]        div_res;
    logic [63:0]        mul_res;

    assign accept   = (state_q == S_IDLE) && md_start && !md_cancel;
    assign mul_last = (cnt_q == CNT_W'(MUL_LAST));
    assign div_last = (cnt_q == CNT_W'(DIV_LAST));

    // Divide datapath: magnitudes, one restoring iteration, final sign fix-up
    always_comb begin
        dvd_in_abs = (!md_op[0] && md_src1[31]) ? 32'(-md_src1) : md_src1;
        dvs_abs    = (!uns_q && src2_q[31]) ? 32'(-src2_q) : src2_q;
        rem_sh     = rq_q[63:31];
        diff       = rem_sh - {1'b0, dvs_abs};
        if (!diff[32]) begin
            rq_iter = {diff[31:0], rq_q[30:0], 1'b1};
        end else begin
            rq_iter = {rem_sh[31:0], rq_q[30:0], 1'b0};
        end
        quo   = rq_iter[31:0];
        rem   = rq_iter[63:32];
        q_neg = !uns_q && (src1_q[31] ^ src2_q[31]);
        r_neg = !uns_q && src1_q[31];
        if (src2_q == 32'd0) begin
            div_res = {src1_q, 32'hFFFF_FFFF};
        end else begin
            div_res = {(r_neg ? 32'(-rem) : rem), (q_neg ? 32'(-quo) : quo)};
        end
    end

    // Multiply datapath: sign- or zero-extend to 64 bits and take the low 64 of the product
    always_comb begin
        if (uns_q) begin
            mul_res = {32'd0, src1_q} * {32'd0, src2_q};
        end else begin
            mul_res = {{32{src1_q[31]}}, src1_q} * {{32{src2_q[31]}}, src2_q};
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            uns_q    <= 1'b0;
            src1_q   <= 32'd0;
            src2_q   <= 32'd0;
            cnt_q    <= '0;
            rq_q     <= 64'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            uns_q    <= uns_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            cnt_q    <= cnt_d;
            rq_q     <= rq_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = md_op[1] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                if (md_cancel)     state_d = S_IDLE;
                else if (mul_last) state_d = S_DONE;
            end
            S_DIV: begin
                if (md_cancel)     state_d = S_IDLE;
                else if (div_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration count, result load
    always_comb begin
        uns_d    = uns_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        cnt_d    = cnt_q;
        rq_d     = rq_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    uns_d  = md_op[0];
                    src1_d = md_src1;
                    src2_d = md_src2;
                    cnt_d  = '0;
                    rq_d   = {32'd0, dvd_in_abs};
                end
            end
            S_MUL: begin
                if (md_cancel) begin
                    cnt_d = '0;
                end else if (mul_last) begin
                    cnt_d    = '0;
                    result_d = mul_res;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (md_cancel) begin
                    cnt_d = '0;
                end else if (div_last) begin
                    cnt_d    = '0;
                    rq_d     = rq_iter;
                    result_d = div_res;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rq_d  = rq_iter;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        md_busy = (state_q != S_IDLE);
        md_done = (state_q == S_DONE);
    end

    assign md_result = result_q;

endmodule
